// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall polarity, reset level
// and the flush FSM states.
package pipe_ctrl_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// timeout once the count has sat at WDOG_MAX for an edge.
import pipe_ctrl_pkg::*;

module stall_wdog #(
    parameter int WDOG_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clr,
    output logic timeout
);

    localparam int CW = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(WDOG_MAX);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          timeout_r;
    logic          timeout_s;

    // Next count and sticky flag; clr wins over a simultaneous set.
    always_comb begin
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
        if (clr) begin
            cnt_s     = {CW{1'b0}};
            timeout_s = 1'b0;
        end else begin
            if (cnt_r == MAX_C) begin
                timeout_s = 1'b1;
            end else begin
                timeout_s = timeout_r;
            end
            if (!active) begin
                cnt_s = {CW{1'b0}};
            end else if (cnt_r == MAX_C) begin
                cnt_s = cnt_r;
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            cnt_r     <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall fan-out, registered flush
// redirect, stall watchdog and saturating stall-cycle counter.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int NSTAGE   = 6,
    parameter int PC_W     = 32,
    parameter int WDOG_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              wdog_clr,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);

    pipe_state_e       state_r;
    pipe_state_e       state_s;
    logic [NSTAGE-1:0] hold_s;
    logic              stall_any_s;
    logic [PC_W-1:0]   new_pc_r;
    logic [PC_W-1:0]   new_pc_s;
    logic [CNT_W-1:0]  cyc_r;
    logic [CNT_W-1:0]  cyc_s;

    // A request at stage k holds every older stage 0..k.
    always_comb begin
        hold_s = {NSTAGE{NO_STOP}};
        hold_s[NSTAGE-1] = (stallreq[NSTAGE-1] == STOP);
        for (int i = NSTAGE - 2; i >= 0; i--) begin
            hold_s[i] = hold_s[i+1] | (stallreq[i] == STOP);
        end
    end

    // Holds are released during reset and while the flush pulse is out.
    always_comb begin
        stall = {NSTAGE{NO_STOP}};
        if ((rst_n == RST_ENABLE) || (state_r == ST_FLUSH)) begin
            stall = {NSTAGE{NO_STOP}};
        end else begin
            stall = hold_s;
        end
    end

    assign stall_any_s = |stall;

    // Flush FSM next state, redirect capture and stall counter update.
    always_comb begin
        state_s  = state_r;
        new_pc_s = new_pc_r;
        cyc_s    = cyc_r;
        case (state_r)
            ST_RUN: begin
                if (flush_req) state_s = ST_FLUSH;
                else           state_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (flush_req) state_s = ST_FLUSH;
                else           state_s = ST_RUN;
            end
            default: state_s = ST_RUN;
        endcase
        if (flush_req) begin
            new_pc_s = flush_pc;
        end else begin
            new_pc_s = new_pc_r;
        end
        if (stall_any_s && (cyc_r != {CNT_W{1'b1}})) begin
            cyc_s = cyc_r + CNT_W'(1);
        end else begin
            cyc_s = cyc_r;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            state_r  <= ST_RUN;
            new_pc_r <= {PC_W{1'b0}};
            cyc_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            new_pc_r <= new_pc_s;
            cyc_r    <= cyc_s;
        end
    end

    assign flush        = (state_r == ST_FLUSH);
    assign new_pc       = new_pc_r;
    assign stall_cycles = cyc_r;

    stall_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (stall_any_s),
        .clr     (wdog_clr),
        .timeout (stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed rows push hand-computed outputs,
// a monitor pops and compares them at the falling edge or on demand.
module tb_pipe_ctrl;

    localparam int NSTAGE   = 6;
    localparam int PC_W     = 32;
    localparam int WDOG_MAX = 4;
    localparam int CNT_W    = 3;

    typedef struct {
        int                id;
        logic [NSTAGE-1:0] stall;
        logic              flush;
        logic [PC_W-1:0]   new_pc;
        logic              timeout;
        logic [CNT_W-1:0]  cycles;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NSTAGE-1:0] stallreq;
    logic              flush_req;
    logic [PC_W-1:0]   flush_pc;
    logic              wdog_clr;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic              stall_timeout;
    logic [CNT_W-1:0]  stall_cycles;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event chk_now;

    pipe_ctrl #(
        .NSTAGE   (NSTAGE),
        .PC_W     (PC_W),
        .WDOG_MAX (WDOG_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stallreq      (stallreq),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .wdog_clr      (wdog_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int id, input logic [NSTAGE-1:0] e_stall,
                            input logic e_flush, input logic [PC_W-1:0] e_pc,
                            input logic e_to, input logic [CNT_W-1:0] e_cyc);
        exp_t e;
        e.id      = id;
        e.stall   = e_stall;
        e.flush   = e_flush;
        e.new_pc  = e_pc;
        e.timeout = e_to;
        e.cycles  = e_cyc;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the rising edge, expect outputs for this cycle.
    task automatic row(input int id, input logic [NSTAGE-1:0] sr, input logic fr,
                       input logic [PC_W-1:0] pc, input logic clr,
                       input logic [NSTAGE-1:0] e_stall, input logic e_flush,
                       input logic [PC_W-1:0] e_pc, input logic e_to,
                       input logic [CNT_W-1:0] e_cyc);
        @(posedge clk);
        #1;
        stallreq  = sr;
        flush_req = fr;
        flush_pc  = pc;
        wdog_clr  = clr;
        push_exp(id, e_stall, e_flush, e_pc, e_to, e_cyc);
    endtask

    // Monitor: compare the oldest expectation against the live outputs.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if ({stall, flush, new_pc, stall_timeout, stall_cycles} ===
                    {e.stall, e.flush, e.new_pc, e.timeout, e.cycles}) begin
                    n_pass++;
                end else begin
                    $display("FAIL row%0d: got stall=%b flush=%b new_pc=%h to=%b cyc=%0d, want stall=%b flush=%b new_pc=%h to=%b cyc=%0d",
                             e.id, stall, flush, new_pc, stall_timeout, stall_cycles,
                             e.stall, e.flush, e.new_pc, e.timeout, e.cycles);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        stallreq  = 6'b111111;
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        wdog_clr  = 1'b0;
        #1;
        push_exp(0, 6'b000000, 1'b0, 32'h0, 1'b0, 3'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        stallreq = 6'b000000;

        // Stall fan-out
        row(1, 6'b001000, 1'b0, 32'h0, 1'b0, 6'b001111, 1'b0, 32'h0, 1'b0, 3'd0);
        row(2, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h0, 1'b0, 3'd1);
        row(3, 6'b000000, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 3'd2);
        // Flush beats a simultaneous stall request
        row(4, 6'b001000, 1'b1, 32'h40, 1'b0, 6'b001111, 1'b0, 32'h0,  1'b0, 3'd2);
        row(5, 6'b001000, 1'b0, 32'h0,  1'b0, 6'b000000, 1'b1, 32'h40, 1'b0, 3'd3);
        row(6, 6'b000000, 1'b0, 32'h0,  1'b0, 6'b000000, 1'b0, 32'h40, 1'b0, 3'd3);
        // Held flush request
        row(7,  6'b000000, 1'b1, 32'h10, 1'b0, 6'b000000, 1'b0, 32'h40, 1'b0, 3'd3);
        row(8,  6'b000000, 1'b1, 32'h20, 1'b0, 6'b000000, 1'b1, 32'h10, 1'b0, 3'd3);
        row(9,  6'b000000, 1'b1, 32'h30, 1'b0, 6'b000000, 1'b1, 32'h20, 1'b0, 3'd3);
        row(10, 6'b000000, 1'b0, 32'h0,  1'b0, 6'b000000, 1'b1, 32'h30, 1'b0, 3'd3);
        row(11, 6'b000000, 1'b0, 32'h0,  1'b0, 6'b000000, 1'b0, 32'h30, 1'b0, 3'd3);
        // Long stall: counter saturates at 7, timeout after the 5th stalled edge
        row(12, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd3);
        row(13, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd4);
        row(14, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd5);
        row(15, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd6);
        row(16, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd7);
        for (int k = 17; k <= 21; k++) begin
            row(k, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b1, 3'd7);
        end
        row(22, 6'b000100, 1'b0, 32'h0, 1'b1, 6'b000111, 1'b0, 32'h30, 1'b1, 3'd7);
        row(23, 6'b000000, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h30, 1'b0, 3'd7);
        // Clear on the very edge the timeout would set
        for (int k = 24; k <= 27; k++) begin
            row(k, 6'b000100, 1'b0, 32'h0, 1'b0, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd7);
        end
        row(28, 6'b000100, 1'b0, 32'h0, 1'b1, 6'b000111, 1'b0, 32'h30, 1'b0, 3'd7);
        row(29, 6'b000000, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h30, 1'b0, 3'd7);
        // Reset dropped mid-flush
        row(30, 6'b000000, 1'b1, 32'h55, 1'b0, 6'b000000, 1'b0, 32'h30, 1'b0, 3'd7);
        row(31, 6'b001000, 1'b0, 32'h0,  1'b0, 6'b000000, 1'b1, 32'h55, 1'b0, 3'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(32, 6'b000000, 1'b0, 32'h0, 1'b0, 3'd0);
        ->chk_now;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        stallreq = 6'b000000;
        row(33, 6'b000000, 1'b0, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 3'd0);
        row(34, 6'b000001, 1'b0, 32'h0, 1'b0, 6'b000001, 1'b0, 32'h0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);

        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
